// File: rtl/tcp_tx_noc_out_pkg.sv
// Shared types and helpers for the TCP TX NoC egress packetiser.
package tcp_tx_noc_out_pkg;

  localparam int unsigned IP_ADDR_W        = 32;
  localparam int unsigned TOT_LEN_W        = 16;
  localparam int unsigned PROTOCOL_W       = 8;
  localparam int unsigned MAC_PADBYTES_W   = 6;
  localparam int unsigned XY_WIDTH         = 8;
  localparam int unsigned FBITS_W          = 4;
  localparam int unsigned MSG_LENGTH_WIDTH = 22;
  localparam int unsigned MSG_TYPE_W       = 8;

  localparam logic [XY_WIDTH-1:0]   IP_TX_X        = 8'd2;
  localparam logic [XY_WIDTH-1:0]   IP_TX_Y        = 8'd0;
  localparam logic [FBITS_W-1:0]    PKT_IF_FBITS   = 4'b1000;
  localparam logic [MSG_TYPE_W-1:0] IP_TX_DATAGRAM = 8'd10;

  typedef struct packed {
    logic [XY_WIDTH-1:0]         dst_x_coord;
    logic [XY_WIDTH-1:0]         dst_y_coord;
    logic [FBITS_W-1:0]          dst_fbits;
    logic [MSG_LENGTH_WIDTH-1:0] msg_len;
    logic [MSG_TYPE_W-1:0]       msg_type;
    logic [XY_WIDTH-1:0]         src_x_coord;
    logic [XY_WIDTH-1:0]         src_y_coord;
    logic [FBITS_W-1:0]          src_fbits;
    logic [7:0]                  metadata_flits;
  } beehive_noc_hdr_flit;

  typedef struct packed {
    logic [IP_ADDR_W-1:0]  src_ip;
    logic [IP_ADDR_W-1:0]  dst_ip;
    logic [TOT_LEN_W-1:0]  data_payload_len;
    logic [PROTOCOL_W-1:0] protocol;
  } ip_tx_metadata_flit;

  localparam int unsigned HDR_FLIT_W  = $bits(beehive_noc_hdr_flit);
  localparam int unsigned META_FLIT_W = $bits(ip_tx_metadata_flit);

  typedef enum logic [1:0] {StIdle, StHdr, StMeta, StData} state_e;
  typedef enum logic [1:0] {FlitNone, FlitHdr, FlitMeta, FlitData} flit_sel_e;

  // Data flits per segment: ceil(len / bytes_w), bytes_w a power of two.
  function automatic logic [MSG_LENGTH_WIDTH-1:0] n_data(input logic [TOT_LEN_W-1:0] len,
                                                         input int unsigned bytes_w);
    int unsigned          sh;
    logic [TOT_LEN_W-1:0] low_mask;
    sh       = $clog2(bytes_w);
    low_mask = TOT_LEN_W'(bytes_w - 1);
    n_data   = MSG_LENGTH_WIDTH'(len >> sh) + MSG_LENGTH_WIDTH'((len & low_mask) != '0);
  endfunction

endpackage

// File: rtl/tcp_tx_noc_out_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr wins.
module tcp_tx_noc_out_rr_arb #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int unsigned cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = (32'(ptr) + i) % NUM_SRC;
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcp_tx_noc_out_mux.sv
// TCP TX NoC egress packetiser: rr-arbitrated header + metadata + data flits onto noc0.
// Optional length/padbytes checking is enabled by defining TCP_TX_NOC_OUT_LEN_CHK_EN.
module tcp_tx_noc_out_mux
  import tcp_tx_noc_out_pkg::*;
#(
  parameter int          SRC_X      = -1,
  parameter int          SRC_Y      = -1,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned NOC_DATA_W = 512
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_SRC-1:0]                 src_hdr_val,
  input  logic [NUM_SRC*IP_ADDR_W-1:0]       src_hdr_src_ip,
  input  logic [NUM_SRC*IP_ADDR_W-1:0]       src_hdr_dst_ip,
  input  logic [NUM_SRC*TOT_LEN_W-1:0]       src_hdr_tcp_len,
  input  logic [NUM_SRC*PROTOCOL_W-1:0]      src_hdr_protocol,
  output logic [NUM_SRC-1:0]                 src_hdr_rdy,
  input  logic [NUM_SRC-1:0]                 src_data_val,
  input  logic [NUM_SRC*NOC_DATA_W-1:0]      src_data,
  input  logic [NUM_SRC-1:0]                 src_data_last,
  input  logic [NUM_SRC*MAC_PADBYTES_W-1:0]  src_data_padbytes,
  output logic [NUM_SRC-1:0]                 src_data_rdy,
  output logic                               tx_out_noc0_val,
  output logic [NOC_DATA_W-1:0]              tx_out_noc0_data,
  input  logic                               noc0_tx_out_rdy,
  output logic                               tx_out_err
);

  localparam int unsigned NOC_DATA_BYTES = NOC_DATA_W / 8;
  localparam int unsigned IDX_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned HDR_PAD        = NOC_DATA_W - HDR_FLIT_W;
  localparam int unsigned META_PAD       = NOC_DATA_W - META_FLIT_W;

  state_e                      state_q, state_d;
  flit_sel_e                   flit_sel;
  logic [IDX_W-1:0]            rr_ptr_q, rr_ptr_d, grant_q, next_ptr;
  logic [IP_ADDR_W-1:0]        src_ip_q, dst_ip_q;
  logic [TOT_LEN_W-1:0]        tcp_len_q;
  logic [PROTOCOL_W-1:0]       protocol_q;
  logic [MSG_LENGTH_WIDTH-1:0] n_data_q;
  logic                        capture;

  logic [NUM_SRC-1:0]          arb_grant;
  logic [IDX_W-1:0]            arb_idx;
  logic                        arb_any;

  logic                        sel_val, sel_last;
  logic [NOC_DATA_W-1:0]       sel_data;
  beehive_noc_hdr_flit         hdr_flit;
  ip_tx_metadata_flit          meta_flit;

  tcp_tx_noc_out_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .req       (src_hdr_val),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign sel_val  = src_data_val[grant_q];
  assign sel_last = src_data_last[grant_q];
  assign sel_data = src_data[grant_q*NOC_DATA_W +: NOC_DATA_W];
  assign next_ptr = (32'(grant_q) == NUM_SRC - 1) ? '0 : grant_q + IDX_W'(1);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    flit_sel     = FlitNone;
    src_hdr_rdy  = '0;
    src_data_rdy = '0;
    capture      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          src_hdr_rdy = arb_grant;
          capture     = 1'b1;
          state_d     = StHdr;
        end
      end
      StHdr: begin
        flit_sel = FlitHdr;
        if (noc0_tx_out_rdy) state_d = StMeta;
      end
      StMeta: begin
        flit_sel = FlitMeta;
        if (noc0_tx_out_rdy) begin
          // A zero-length segment completes here, so it also advances the rr pointer.
          if (tcp_len_q == '0) begin
            state_d  = StIdle;
            rr_ptr_d = next_ptr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        flit_sel              = FlitData;
        src_data_rdy[grant_q] = noc0_tx_out_rdy;
        if (sel_val && noc0_tx_out_rdy && sel_last) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hdr_flit                = '0;
    hdr_flit.dst_x_coord    = IP_TX_X;
    hdr_flit.dst_y_coord    = IP_TX_Y;
    hdr_flit.dst_fbits      = PKT_IF_FBITS;
    hdr_flit.msg_len        = n_data_q + MSG_LENGTH_WIDTH'(1);
    hdr_flit.msg_type       = IP_TX_DATAGRAM;
    hdr_flit.src_x_coord    = XY_WIDTH'(SRC_X);
    hdr_flit.src_y_coord    = XY_WIDTH'(SRC_Y);
    hdr_flit.src_fbits      = PKT_IF_FBITS;
    hdr_flit.metadata_flits = 8'd1;

    meta_flit                  = '0;
    meta_flit.src_ip           = src_ip_q;
    meta_flit.dst_ip           = dst_ip_q;
    meta_flit.data_payload_len = tcp_len_q;
    meta_flit.protocol         = protocol_q;
  end

  always_comb begin
    tx_out_noc0_val  = 1'b0;
    tx_out_noc0_data = '0;
    unique case (flit_sel)
      FlitHdr: begin
        tx_out_noc0_val  = 1'b1;
        tx_out_noc0_data = {hdr_flit, {HDR_PAD{1'b0}}};
      end
      FlitMeta: begin
        tx_out_noc0_val  = 1'b1;
        tx_out_noc0_data = {meta_flit, {META_PAD{1'b0}}};
      end
      FlitData: begin
        tx_out_noc0_val  = sel_val;
        tx_out_noc0_data = sel_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      tcp_len_q  <= '0;
      protocol_q <= '0;
      n_data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (capture) begin
        grant_q    <= arb_idx;
        src_ip_q   <= src_hdr_src_ip[arb_idx*IP_ADDR_W +: IP_ADDR_W];
        dst_ip_q   <= src_hdr_dst_ip[arb_idx*IP_ADDR_W +: IP_ADDR_W];
        tcp_len_q  <= src_hdr_tcp_len[arb_idx*TOT_LEN_W +: TOT_LEN_W];
        protocol_q <= src_hdr_protocol[arb_idx*PROTOCOL_W +: PROTOCOL_W];
        n_data_q   <= n_data(src_hdr_tcp_len[arb_idx*TOT_LEN_W +: TOT_LEN_W], NOC_DATA_BYTES);
      end
    end
  end

`ifdef TCP_TX_NOC_OUT_LEN_CHK_EN
  logic [MSG_LENGTH_WIDTH-1:0] flit_cnt_q, flit_cnt_inc;
  logic [MAC_PADBYTES_W-1:0]   sel_pad, exp_pad;
  logic                        data_fire, len_bad, err_q;

  assign sel_pad      = src_data_padbytes[grant_q*MAC_PADBYTES_W +: MAC_PADBYTES_W];
  assign exp_pad      = MAC_PADBYTES_W'((NOC_DATA_BYTES - 32'(tcp_len_q) % NOC_DATA_BYTES)
                                        % NOC_DATA_BYTES);
  assign data_fire    = (state_q == StData) && sel_val && noc0_tx_out_rdy;
  assign flit_cnt_inc = flit_cnt_q + MSG_LENGTH_WIDTH'(1);
  // Flag but keep forwarding: a missing last still drains the source up to its real last.
  assign len_bad      = data_fire && (sel_last ? ((flit_cnt_inc != n_data_q) ||
                                                  (sel_pad != exp_pad))
                                               : (flit_cnt_inc == n_data_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (capture) begin
        flit_cnt_q <= '0;
      end else if (data_fire) begin
        flit_cnt_q <= flit_cnt_inc;
      end
      if (len_bad) err_q <= 1'b1;
    end
  end

  assign tx_out_err = err_q;
`else
  logic unused_padbytes;
  assign unused_padbytes = ^src_data_padbytes;
  assign tx_out_err      = 1'b0;
`endif

endmodule

// File: tb/tb_tcp_tx_noc_out_mux.sv
// Self-checking bench for tcp_tx_noc_out_mux: directed cases plus randomized traffic vs a model.
module tb_tcp_tx_noc_out_mux;
  import tcp_tx_noc_out_pkg::*;

  localparam int NS       = 3;
  localparam int W        = 512;
  localparam int BYTES    = W / 8;
  localparam int TB_SRC_X = 3;
  localparam int TB_SRC_Y = 5;
  localparam int MAXF     = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS-1:0]                src_hdr_val = '0;
  logic [NS*IP_ADDR_W-1:0]      src_hdr_src_ip = '0;
  logic [NS*IP_ADDR_W-1:0]      src_hdr_dst_ip = '0;
  logic [NS*TOT_LEN_W-1:0]      src_hdr_tcp_len = '0;
  logic [NS*PROTOCOL_W-1:0]     src_hdr_protocol = '0;
  logic [NS-1:0]                src_hdr_rdy;
  logic [NS-1:0]                src_data_val = '0;
  logic [NS*W-1:0]              src_data = '0;
  logic [NS-1:0]                src_data_last = '0;
  logic [NS*MAC_PADBYTES_W-1:0] src_data_padbytes = '0;
  logic [NS-1:0]                src_data_rdy;
  logic                         tx_out_noc0_val;
  logic [W-1:0]                 tx_out_noc0_data;
  logic                         noc0_tx_out_rdy = 1'b1;
  logic                         tx_out_err;

  tcp_tx_noc_out_mux #(
    .SRC_X      (TB_SRC_X),
    .SRC_Y      (TB_SRC_Y),
    .NUM_SRC    (NS),
    .NOC_DATA_W (W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .src_hdr_val       (src_hdr_val),
    .src_hdr_src_ip    (src_hdr_src_ip),
    .src_hdr_dst_ip    (src_hdr_dst_ip),
    .src_hdr_tcp_len   (src_hdr_tcp_len),
    .src_hdr_protocol  (src_hdr_protocol),
    .src_hdr_rdy       (src_hdr_rdy),
    .src_data_val      (src_data_val),
    .src_data          (src_data),
    .src_data_last     (src_data_last),
    .src_data_padbytes (src_data_padbytes),
    .src_data_rdy      (src_data_rdy),
    .tx_out_noc0_val   (tx_out_noc0_val),
    .tx_out_noc0_data  (tx_out_noc0_data),
    .noc0_tx_out_rdy   (noc0_tx_out_rdy),
    .tx_out_err        (tx_out_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0]          expq[$];
  int                    grant_log[$];
  logic [W-1:0]          dbuf[NS][MAXF];
  int                    dcnt[NS], dpos[NS], plen[NS], ppad[NS];
  logic [IP_ADDR_W-1:0]  psip[NS], pdip[NS];
  logic [PROTOCOL_W-1:0] pproto[NS];
  logic [NS-1:0]         busy = '0, presenting = '0;
  int rr_ptr_m = 0, cur_ch = 0, remaining = 0, cyc = 0, t_grant = 0, t_last = 0;
  int out_cnt = 0, done_cnt = 0;
  logic model_err = 1'b0;
  bit rdy_rand = 1'b0, val_rand = 1'b0;
  logic hold_v = 1'b0;
  logic [W-1:0] held = '0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_flit();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [W-1:0] exp_hdr(input int len);
    beehive_noc_hdr_flit h;
    h                = '0;
    h.dst_x_coord    = IP_TX_X;
    h.dst_y_coord    = IP_TX_Y;
    h.dst_fbits      = PKT_IF_FBITS;
    h.msg_len        = MSG_LENGTH_WIDTH'(1 + (len + BYTES - 1) / BYTES);
    h.msg_type       = IP_TX_DATAGRAM;
    h.src_x_coord    = 8'(TB_SRC_X);
    h.src_y_coord    = 8'(TB_SRC_Y);
    h.src_fbits      = PKT_IF_FBITS;
    h.metadata_flits = 8'd1;
    return {h, {(W - HDR_FLIT_W){1'b0}}};
  endfunction

  function automatic logic [W-1:0] exp_meta(input int c);
    ip_tx_metadata_flit m;
    m.src_ip           = psip[c];
    m.dst_ip           = pdip[c];
    m.data_payload_len = 16'(plen[c]);
    m.protocol         = pproto[c];
    return {m, {(W - META_FLIT_W){1'b0}}};
  endfunction

  task automatic issue(input int c, input int len, input int nfl, input int pad);
    plen[c]   = len;
    dcnt[c]   = nfl;
    dpos[c]   = 0;
    ppad[c]   = pad;
    psip[c]   = $urandom;
    pdip[c]   = $urandom;
    pproto[c] = 8'($urandom);
    for (int i = 0; i < nfl; i++) dbuf[c][i] = rand_flit();
    src_hdr_src_ip[c*IP_ADDR_W +: IP_ADDR_W]    = psip[c];
    src_hdr_dst_ip[c*IP_ADDR_W +: IP_ADDR_W]    = pdip[c];
    src_hdr_tcp_len[c*TOT_LEN_W +: TOT_LEN_W]   = 16'(len);
    src_hdr_protocol[c*PROTOCOL_W +: PROTOCOL_W] = pproto[c];
    src_hdr_val[c] = 1'b1;
    busy[c]        = 1'b1;
    presenting[c]  = 1'b0;
  endtask

  task automatic issue_ok(input int c, input int len);
    issue(c, len, (len + BYTES - 1) / BYTES, (BYTES - len % BYTES) % BYTES);
  endtask

  task automatic pkt_done(input int c);
    rr_ptr_m      = (c + 1) % NS;
    busy[c]       = 1'b0;
    presenting[c] = 1'b0;
    done_cnt++;
`ifdef TCP_TX_NOC_OUT_LEN_CHK_EN
    if (dcnt[c] != (plen[c] + BYTES - 1) / BYTES ||
        (dcnt[c] > 0 && ppad[c] != (BYTES - plen[c] % BYTES) % BYTES))
      model_err = 1'b1;
`endif
  endtask

  // One clock: sample handshakes at negedge, update source/sink drive just after posedge.
  task automatic cycle();
    logic [NS-1:0] hf, df;
    logic          of;
    logic [W-1:0]  flit;
    int            pick;
    @(negedge clk);
    hf   = src_hdr_val & src_hdr_rdy;
    df   = src_data_val & src_data_rdy;
    of   = tx_out_noc0_val & noc0_tx_out_rdy;
    flit = tx_out_noc0_data;
    if (hold_v) begin
      chk("hold_val", W'(tx_out_noc0_val), W'(1));
      chk("hold_data", flit, held);
    end
    hold_v = tx_out_noc0_val && !noc0_tx_out_rdy;
    held   = flit;
    if (hf != '0) begin
      pick = -1;
      for (int i = 0; i < NS; i++) begin
        int c;
        c = (rr_ptr_m + i) % NS;
        if (pick < 0 && src_hdr_val[c]) pick = c;
      end
      chk("grant", W'(hf), W'(1) << pick);
      grant_log.push_back(pick);
      cur_ch    = pick;
      remaining = 2 + dcnt[pick];
      t_grant   = cyc;
      expq.push_back(exp_hdr(plen[pick]));
      expq.push_back(exp_meta(pick));
      for (int i = 0; i < dcnt[pick]; i++) expq.push_back(dbuf[pick][i]);
    end
    if (of) begin
      if (expq.size() == 0) chk("spurious_flit", W'(expq.size()), W'(1));
      else chk("flit", flit, expq.pop_front());
      out_cnt++;
      t_last = cyc;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) pkt_done(cur_ch);
      end
    end
    for (int c = 0; c < NS; c++) if (df[c]) dpos[c]++;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < NS; c++) begin
      if (hf[c]) begin
        src_hdr_val[c] = 1'b0;
        presenting[c]  = 1'b1;
        // Scramble header inputs: the DUT must use its captured copy.
        src_hdr_src_ip[c*IP_ADDR_W +: IP_ADDR_W]  = $urandom;
        src_hdr_dst_ip[c*IP_ADDR_W +: IP_ADDR_W]  = $urandom;
        src_hdr_tcp_len[c*TOT_LEN_W +: TOT_LEN_W] = 16'($urandom);
      end
      if (presenting[c] && dpos[c] < dcnt[c]) begin
        if (df[c] || !src_data_val[c]) begin
          src_data_val[c] = val_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
          src_data[c*W +: W] = dbuf[c][dpos[c]];
          src_data_last[c] = (dpos[c] == dcnt[c] - 1);
          src_data_padbytes[c*MAC_PADBYTES_W +: MAC_PADBYTES_W] =
            src_data_last[c] ? MAC_PADBYTES_W'(ppad[c]) : '0;
        end
      end else begin
        src_data_val[c]  = 1'b0;
        src_data_last[c] = 1'b0;
      end
    end
    noc0_tx_out_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic run_idle(input string tag, input int bound);
    int n;
    n = 0;
    while ((busy != '0 || expq.size() != 0) && n < bound) begin
      cycle();
      n++;
    end
    chk({tag, "_drain"}, W'(n < bound), W'(1));
  endtask

  initial begin
    int issued, n;
    #12;
    chk("rst_hdr_rdy", W'(src_hdr_rdy), W'(0));
    chk("rst_data_rdy", W'(src_data_rdy), W'(0));
    chk("rst_val", W'(tx_out_noc0_val), W'(0));
    chk("rst_err", W'(tx_out_err), W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // len 100: msg_len 3, two data flits, minimum latency
    out_cnt = 0;
    issue_ok(0, 100);
    run_idle("len100", 50);
    chk("len100_flits", W'(out_cnt), W'(4));
    chk("len100_latency", W'(t_last - t_grant), W'(4));

    out_cnt = 0;
    issue_ok(1, 128);
    run_idle("len128", 50);
    chk("len128_flits", W'(out_cnt), W'(4));

    out_cnt = 0;
    issue_ok(2, 0);
    run_idle("len0", 50);
    chk("len0_flits", W'(out_cnt), W'(2));

    out_cnt = 0;
    issue_ok(2, 64);
    run_idle("len64", 50);
    chk("len64_flits", W'(out_cnt), W'(3));

    // All three requesting at once: rr pointer is back at 0
    grant_log.delete();
    issue_ok(0, 10);
    issue_ok(1, 70);
    issue_ok(2, 130);
    run_idle("rr1", 100);
    chk("rr1_n", W'(grant_log.size()), W'(3));
    chk("rr1_order", W'({grant_log[0], grant_log[1], grant_log[2]}), W'({32'd0, 32'd1, 32'd2}));

    // Serve ch0 alone, then all three: ch0 must wait behind ch1 and ch2
    issue_ok(0, 20);
    run_idle("rr_solo", 50);
    grant_log.delete();
    issue_ok(0, 30);
    issue_ok(1, 40);
    issue_ok(2, 50);
    run_idle("rr2", 100);
    chk("rr2_n", W'(grant_log.size()), W'(3));
    chk("rr2_order", W'({grant_log[0], grant_log[1], grant_log[2]}), W'({32'd1, 32'd2, 32'd0}));

    // Randomized traffic with backpressure on both sides
    rdy_rand = 1'b1;
    val_rand = 1'b1;
    issued   = 0;
    done_cnt = 0;
    n        = 0;
    while (issued < 30 && n < 6000) begin
      for (int c = 0; c < NS; c++) begin
        if (!busy[c] && issued < 30 && $urandom_range(0, 3) == 0) begin
          issue_ok(c, $urandom_range(1, 255));
          issued++;
        end
      end
      cycle();
      n++;
    end
    run_idle("rand", 6000);
    chk("rand_pkts", W'(done_cnt), W'(30));
    rdy_rand = 1'b0;
    val_rand = 1'b0;
    cycle();

    // Reset in the middle of the data phase
    issue_ok(1, 200);
    n = 0;
    while (remaining != 3 && n < 50) begin
      cycle();
      n++;
    end
    chk("mid_data_reached", W'(remaining), W'(3));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_val", W'(tx_out_noc0_val), W'(0));
    chk("mid_rst_data_rdy", W'(src_data_rdy), W'(0));
    chk("mid_rst_hdr_rdy", W'(src_hdr_rdy), W'(0));
    expq.delete();
    src_hdr_val  = '0;
    src_data_val = '0;
    busy         = '0;
    presenting   = '0;
    remaining    = 0;
    hold_v       = 1'b0;
    rr_ptr_m     = 0;
    cycle();
    cycle();
    rst_n = 1'b1;
    out_cnt = 0;
    issue_ok(0, 100);
    run_idle("post_rst", 50);
    chk("post_rst_flits", W'(out_cnt), W'(4));

    // Length error: 100 bytes sent as three data flits, last on the third
    out_cnt = 0;
    issue(0, 100, 3, 28);
    run_idle("len_err", 50);
    chk("len_err_flits", W'(out_cnt), W'(5));
`ifdef TCP_TX_NOC_OUT_LEN_CHK_EN
    chk("len_err_set", W'(tx_out_err), W'(1));
`else
    chk("len_err_off", W'(tx_out_err), W'(0));
`endif
    issue_ok(1, 50);
    run_idle("after_err", 50);
    chk("err_sticky", W'(tx_out_err), W'(model_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
